// File: rtl/nds_async_fifo_rd_burst.sv
// Burst reader for the read side of an async FIFO: waits until a whole chunk is buffered,
// then streams it through a registered valid/ready output stage.
module nds_async_fifo_rd_burst #(
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned POINTER_INDEX_WIDTH = 4,
    parameter int unsigned BURST_LEN           = 4,
    parameter int unsigned LEN_WIDTH           = 16
) (
    input  logic                           r_clk,
    input  logic                           r_reset,
    input  logic                           req_valid,
    input  logic [LEN_WIDTH-1:0]           req_len,
    output logic                           req_ready,
    input  logic                           abort,
    output logic                           done,
    output logic                           fifo_rd,
    input  logic [DATA_WIDTH-1:0]          fifo_rd_data,
    input  logic                           fifo_empty,
    input  logic [POINTER_INDEX_WIDTH-1:0] fifo_data_num,
    output logic                           fifo_clr,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_last,
    input  logic                           out_ready
);

    localparam int unsigned CMP_WIDTH =
        (LEN_WIDTH > POINTER_INDEX_WIDTH) ? LEN_WIDTH : POINTER_INDEX_WIDTH;
    localparam logic [LEN_WIDTH-1:0] BURST_LEN_L = LEN_WIDTH'(BURST_LEN);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE     = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StBurst,
        StDrain,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    remain_q, remain_d;
    logic [LEN_WIDTH-1:0]    chunk_q, chunk_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic                    fifo_clr_q, fifo_clr_d;
    logic                    pop;
    logic                    beat_taken;
    logic [CMP_WIDTH-1:0]    num_ext;
    logic [CMP_WIDTH-1:0]    chunk_ext;

    function automatic logic [LEN_WIDTH-1:0] first_chunk(input logic [LEN_WIDTH-1:0] len);
        return (len < BURST_LEN_L) ? len : BURST_LEN_L;
    endfunction

    // Both operands zero-extended so the occupancy compare is unsigned at any width mix.
    assign num_ext   = CMP_WIDTH'(fifo_data_num);
    assign chunk_ext = CMP_WIDTH'(chunk_q);

    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        chunk_d     = chunk_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        fifo_clr_d  = 1'b0;
        pop         = 1'b0;
        beat_taken  = out_valid_q && out_ready;

        if (beat_taken) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (abort && (state_q != StIdle)) begin
            state_d     = StIdle;
            remain_d    = '0;
            chunk_d     = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            fifo_clr_d  = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid && !abort) begin
                        remain_d = req_len;
                        chunk_d  = first_chunk(req_len);
                        state_d  = (req_len != '0) ? StWait : StDone;
                    end
                end
                StWait: begin
                    if (num_ext >= chunk_ext) begin
                        state_d = StBurst;
                    end
                end
                StBurst: begin
                    pop = !fifo_empty && (!out_valid_q || out_ready);
                    if (pop) begin
                        remain_d    = remain_q - LEN_ONE;
                        chunk_d     = chunk_q - LEN_ONE;
                        out_valid_d = 1'b1;
                        out_data_d  = fifo_rd_data;
                        out_last_d  = (remain_q == LEN_ONE);
                        if (chunk_q == LEN_ONE) begin
                            if (remain_q != LEN_ONE) begin
                                state_d = StWait;
                                chunk_d = first_chunk(remain_q - LEN_ONE);
                            end else begin
                                state_d = StDrain;
                            end
                        end
                    end
                end
                StDrain: begin
                    if (beat_taken) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge r_clk) begin
        if (r_reset) begin
            state_q     <= StIdle;
            remain_q    <= '0;
            chunk_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            fifo_clr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            chunk_q     <= chunk_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            fifo_clr_q  <= fifo_clr_d;
        end
    end

    // A request offered alongside abort is refused, so ready drops with it.
    assign req_ready = (state_q == StIdle) && !abort;
    assign done      = (state_q == StDone);
    assign fifo_rd   = pop;
    assign fifo_clr  = fifo_clr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_nds_async_fifo_rd_burst.sv
// Directed bench for nds_async_fifo_rd_burst with a pointer-based FIFO model and a beat monitor.
module tb_nds_async_fifo_rd_burst;

    localparam int DW = 32;
    localparam int PW = 4;
    localparam int BL = 4;
    localparam int LW = 16;

    logic          r_clk = 1'b0;
    logic          r_reset;
    logic          req_valid;
    logic [LW-1:0] req_len;
    logic          req_ready;
    logic          abort;
    logic          done;
    logic          fifo_rd;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic [PW-1:0] fifo_data_num;
    logic          fifo_clr;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;

    int checks = 0;
    int errors = 0;

    int unsigned wr_total = 0;
    int unsigned rd_ptr   = 0;
    int          cyc      = 0;
    int          n_pop    = 0;
    int          n_done   = 0;
    int          n_clr    = 0;
    int          n_ov     = 0;
    int          done_cyc = 0;
    int          acc_cyc  = 0;
    int          pop_cyc[$];
    logic [DW-1:0] beat_data[$];
    logic          beat_last[$];

    nds_async_fifo_rd_burst #(
        .DATA_WIDTH          (DW),
        .POINTER_INDEX_WIDTH (PW),
        .BURST_LEN           (BL),
        .LEN_WIDTH           (LW)
    ) dut (
        .r_clk         (r_clk),
        .r_reset       (r_reset),
        .req_valid     (req_valid),
        .req_len       (req_len),
        .req_ready     (req_ready),
        .abort         (abort),
        .done          (done),
        .fifo_rd       (fifo_rd),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_empty    (fifo_empty),
        .fifo_data_num (fifo_data_num),
        .fifo_clr      (fifo_clr),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_ready     (out_ready)
    );

    always #5 r_clk = ~r_clk;

    function automatic logic [DW-1:0] word_of(input int unsigned k);
        return DW'(32'hC0DE_0000 + k);
    endfunction

    // FIFO contents are words rd_ptr .. wr_total-1; the bench only ever advances wr_total.
    assign fifo_empty    = (wr_total == rd_ptr);
    assign fifo_data_num = PW'(wr_total - rd_ptr);
    assign fifo_rd_data  = word_of(rd_ptr);

    always @(posedge r_clk) begin
        cyc <= cyc + 1;
        if (fifo_clr) rd_ptr <= wr_total;
        else if (fifo_rd) rd_ptr <= rd_ptr + 1;
    end

    always @(negedge r_clk) begin
        if (fifo_rd) begin
            n_pop <= n_pop + 1;
            pop_cyc.push_back(cyc);
        end
        if (out_valid) n_ov <= n_ov + 1;
        if (out_valid && out_ready) begin
            beat_data.push_back(out_data);
            beat_last.push_back(out_last);
            if (out_last) acc_cyc <= cyc;
        end
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (fifo_clr) n_clr <= n_clr + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge r_clk);
        #2;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 80 && n_done == d0; i++) tick();
        checks++;
        if (n_done == d0) begin
            errors++;
            $display("FAIL done_timeout: got no done pulse, want one within 80 cycles");
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        r_reset = 1'b1;
        tick();
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", out_last); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %h want 0", out_data); end
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL rst_fifo_rd got %b want 0", fifo_rd); end
        checks++; if (fifo_clr !== 1'b0) begin errors++; $display("FAIL rst_fifo_clr got %b want 0", fifo_clr); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        r_reset = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        checks++; if (fifo_clr !== 1'b0) begin errors++; $display("FAIL idle_abort_clr got %b want 0", fifo_clr); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_abort_ready got %b want 1", req_ready); end
    endtask

    task automatic test_burst10();
        int unsigned w0 = wr_total;
        int p0 = n_pop;
        int b0 = beat_data.size();
        int d0 = n_done;
        int np, nb, bad, g;
        wr_total  = wr_total + 8;
        out_ready = 1'b1;
        req_valid = 1'b1;
        req_len   = 16'd10;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 60 && (n_pop - p0) < 8; i++) tick();
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (n_pop - p0 != 8) begin errors++; $display("FAIL b10_starved_pops got %0d want 8", n_pop - p0); end
        wr_total = wr_total + 2;
        wait_done(d0);
        np = n_pop - p0;
        nb = beat_data.size() - b0;
        checks++; if (np != 10) begin errors++; $display("FAIL b10_pops got %0d want 10", np); end
        bad = 0;
        for (int i = 1; i < np && i < 10; i++) begin
            g = pop_cyc[p0 + i] - pop_cyc[p0 + i - 1];
            if ((i == 4 || i == 8) ? (g < 2) : (g != 1)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b10_burst_shape got %0d bad gaps want 0 (4/4/2)", bad); end
        checks++; if (nb != 10) begin errors++; $display("FAIL b10_beats got %0d want 10", nb); end
        bad = 0;
        for (int i = 0; i < nb && i < 10; i++) if (beat_data[b0 + i] !== word_of(w0 + i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b10_order got %0d wrong beats want 0", bad); end
        bad = 0;
        for (int i = 0; i < nb && i < 10; i++) if (beat_last[b0 + i] !== (i == 9)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b10_last got %0d misplaced want 0", bad); end
        checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL b10_done_count got %0d want 1", n_done - d0); end
        checks++;
        if (done_cyc != acc_cyc + 1) begin
            errors++; $display("FAIL b10_done_latency got cycle %0d want %0d", done_cyc, acc_cyc + 1);
        end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b10_idle got %b want 1", req_ready); end
    endtask

    task automatic test_wait_threshold();
        int unsigned w0 = wr_total;
        int p0 = n_pop;
        int b0 = beat_data.size();
        int d0 = n_done;
        int stray = 0;
        int bad;
        wr_total  = wr_total + 3;
        out_ready = 1'b1;
        req_valid = 1'b1;
        req_len   = 16'd4;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fifo_rd !== 1'b0 || out_valid !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL wait_no_rd got %0d active cycles want 0", stray); end
        checks++; if (n_pop != p0) begin errors++; $display("FAIL wait_pops got %0d want 0", n_pop - p0); end
        wr_total = wr_total + 1;
        wait_done(d0);
        checks++; if (n_pop - p0 != 4) begin errors++; $display("FAIL wait_burst_pops got %0d want 4", n_pop - p0); end
        bad = 0;
        for (int i = 1; i < n_pop - p0 && i < 4; i++) if (pop_cyc[p0 + i] - pop_cyc[p0 + i - 1] != 1) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL wait_consecutive got %0d gaps want 0", bad); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (b0 + i >= beat_data.size()) bad++;
            else if (beat_data[b0 + i] !== word_of(w0 + i)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wait_order got %0d wrong beats want 0", bad); end
    endtask

    task automatic test_backpressure();
        int unsigned w0 = wr_total;
        int p0 = n_pop;
        int b0 = beat_data.size();
        int d0 = n_done;
        int bad;
        wr_total  = wr_total + 4;
        out_ready = 1'b1;
        req_valid = 1'b1;
        req_len   = 16'd4;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 20 && (n_pop - p0) < 2; i++) tick();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== word_of(w0 + 1) || fifo_rd !== 1'b0 ||
                out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h rd=%b l=%b want v=1 d=%h rd=0 l=0",
                         i, out_valid, out_data, fifo_rd, out_last, word_of(w0 + 1));
            end
            tick();
            #1;
        end
        checks++; if (n_pop - p0 != 2) begin errors++; $display("FAIL bp_pops_held got %0d want 2", n_pop - p0); end
        out_ready = 1'b1;
        wait_done(d0);
        checks++;
        if (beat_data.size() - b0 != 4) begin
            errors++; $display("FAIL bp_beats got %0d want 4", beat_data.size() - b0);
        end
        bad = 0;
        for (int i = 0; i < 4 && b0 + i < beat_data.size(); i++)
            if (beat_data[b0 + i] !== word_of(w0 + i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_order got %0d wrong beats want 0", bad); end
    endtask

    task automatic test_abort();
        int p0 = n_pop;
        int d0 = n_done;
        int c0 = n_clr;
        wr_total  = wr_total + 8;
        out_ready = 1'b1;
        req_valid = 1'b1;
        req_len   = 16'd8;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 20 && (n_pop - p0) < 2; i++) tick();
        abort     = 1'b1;
        req_valid = 1'b1;
        req_len   = 16'd3;
        #1;
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL abort_rd got %b want 0", fifo_rd); end
        tick();
        abort     = 1'b0;
        req_valid = 1'b0;
        #1;
        checks++; if (fifo_clr !== 1'b1) begin errors++; $display("FAIL abort_clr got %b want 1", fifo_clr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL abort_last got %b want 0", out_last); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", req_ready); end
        tick();
        #1;
        checks++; if (fifo_clr !== 1'b0) begin errors++; $display("FAIL abort_clr_once got %b want 0", fifo_clr); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (n_clr - c0 != 1) begin errors++; $display("FAIL abort_clr_count got %0d want 1", n_clr - c0); end
        checks++; if (n_done != d0) begin errors++; $display("FAIL abort_no_done got %0d want 0", n_done - d0); end
        checks++; if (n_pop - p0 != 2) begin errors++; $display("FAIL abort_pops got %0d want 2", n_pop - p0); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_req_dropped got %b want 1", req_ready); end
    endtask

    task automatic test_zero_len();
        int p0  = n_pop;
        int ov0 = n_ov;
        int d0  = n_done;
        req_valid = 1'b1;
        req_len   = 16'd0;
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", done); end
        tick();
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b want 0", done); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", req_ready); end
        tick();
        checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL zero_done_count got %0d want 1", n_done - d0); end
        checks++; if (n_pop != p0) begin errors++; $display("FAIL zero_no_rd got %0d want 0", n_pop - p0); end
        checks++; if (n_ov != ov0) begin errors++; $display("FAIL zero_no_valid got %0d want 0", n_ov - ov0); end
    endtask

    task automatic test_reset_in_drain();
        int c0 = n_clr;
        int d0 = n_done;
        wr_total  = wr_total + 1;
        out_ready = 1'b0;
        req_valid = 1'b1;
        req_len   = 16'd1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_setup got v=%b l=%b rdy=%b want v=1 l=1 rdy=0",
                     out_valid, out_last, req_ready);
        end
        r_reset = 1'b1;
        tick();
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL drst_req_ready got %b want 1", req_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drst_out_valid got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL drst_out_last got %b want 0", out_last); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL drst_out_data got %h want 0", out_data); end
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL drst_fifo_rd got %b want 0", fifo_rd); end
        checks++; if (fifo_clr !== 1'b0) begin errors++; $display("FAIL drst_fifo_clr got %b want 0", fifo_clr); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL drst_done got %b want 0", done); end
        r_reset   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        checks++; if (n_clr != c0) begin errors++; $display("FAIL drst_no_clr got %0d want 0", n_clr - c0); end
        checks++; if (n_done != d0) begin errors++; $display("FAIL drst_no_done got %0d want 0", n_done - d0); end
    endtask

    initial begin
        r_reset   = 1'b1;
        req_valid = 1'b0;
        req_len   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_burst10();
        test_wait_threshold();
        test_backpressure();
        test_abort();
        test_zero_len();
        test_reset_in_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nds_async_fifo_rd_burst.md
NDS_ASYNC_FIFO_RD_BURST -- requirements
Module: nds_async_fifo_rd_burst

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the data word width; it matches the upstream FIFO.
REQ-002 SHALL have parameter POINTER_INDEX_WIDTH, default 4, meaning the width of the FIFO occupancy count input.
REQ-003 SHALL have parameter BURST_LEN, default 4, meaning the maximum beats per burst; legal range 1..FIFO_DEPTH.
REQ-004 SHALL have parameter LEN_WIDTH, default 16, meaning the width of the request length and the remaining-beat counter.
REQ-005 Port r_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port r_reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port req_valid, input, 1 bit: a transfer request is offered.
REQ-008 Port req_len, input, LEN_WIDTH bits: number of beats in the request.
REQ-009 Port req_ready, output, 1 bit: the block can accept a request; high only in IDLE.
REQ-010 Port abort, input, 1 bit: cancel the current transfer.
REQ-011 Port done, output, 1 bit: one-cycle pulse when a transfer completes normally.
REQ-012 Port fifo_rd, output, 1 bit: pop strobe to the FIFO read side.
REQ-013 Port fifo_rd_data, input, DATA_WIDTH bits: FIFO head word, valid when fifo_empty is 0.
REQ-014 Port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-015 Port fifo_data_num, input, POINTER_INDEX_WIDTH bits: FIFO read-side occupancy.
REQ-016 Port fifo_clr, output, 1 bit: read-side FIFO clear strobe.
REQ-017 Port out_valid, output, 1 bit: registered output beat is valid.
REQ-018 Port out_data, output, DATA_WIDTH bits: the output beat.
REQ-019 Port out_last, output, 1 bit: marks the final beat of the request.
REQ-020 Port out_ready, input, 1 bit: the downstream stage accepts the beat.

Function
REQ-021 The FSM SHALL have states IDLE, WAIT, BURST, DRAIN and DONE.
REQ-022 In IDLE, req_valid SHALL latch req_len into remain; a nonzero length goes to WAIT and a zero length goes to DONE.
REQ-023 On entering WAIT, chunk SHALL be loaded as min(BURST_LEN, remain).
REQ-024 WAIT SHALL go to BURST only when fifo_data_num >= chunk, compared unsigned and zero-extended.
REQ-025 In BURST, fifo_rd SHALL equal !fifo_empty && (!out_valid || out_ready); it is 0 in every other state.
REQ-026 Each pop SHALL decrement remain and chunk by 1 and load fifo_rd_data into out_data, with out_valid 1 on the next cycle.
REQ-027 out_last SHALL be loaded as 1 when the pop has remain == 1 (the final beat).
REQ-028 Throughput SHALL be one beat per cycle while out_ready stays high and the FIFO is not empty.
REQ-029 out_valid, out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-030 A beat SHALL be accepted when out_valid && out_ready; with no refill in the same cycle, out_valid clears next cycle.
REQ-031 When a pop makes chunk reach 0: if remain is still nonzero the next state SHALL be WAIT, otherwise DRAIN.
REQ-032 DRAIN SHALL go to DONE when the last beat is accepted.
REQ-033 DONE SHALL last one cycle with done = 1, then go to IDLE.
REQ-034 abort, in any state other than IDLE, SHALL take priority over all other events. Next cycle it SHALL produce:
- state IDLE, with remain and chunk at 0;
- out_valid and out_last at 0;
- fifo_clr = 1 for exactly one cycle;
- fifo_rd = 0 in the abort cycle;
- no done pulse.
REQ-035 abort in IDLE SHALL be ignored.
REQ-036 A req_valid arriving in the same cycle as abort SHALL NOT be accepted.
REQ-037 Latency SHALL be one cycle from a pop to out_valid, and one cycle from last-beat acceptance to done.

Reset
REQ-038 When r_reset = 1 at a rising r_clk, the block SHALL enter IDLE with these output values:
- req_ready = 1;
- out_valid = 0, out_last = 0, out_data = 0;
- fifo_rd = 0, fifo_clr = 0, done = 0.
REQ-039 Reset mid-transfer SHALL discard all state and SHALL NOT drive fifo_clr; the FIFO's own reset owns its pointers.

Verification
REQ-040 The bench SHALL cover: req_len = 10, BURST_LEN = 4, FIFO prefilled with 8 words, out_ready held 1 -> bursts of 4, 4 and 2 beats; 10 beats in order; out_last only on beat 10; done 1 cycle later.
REQ-041 The bench SHALL cover: req_len = 4 with fifo_data_num = 3 held for 20 cycles -> stays in WAIT with no fifo_rd; a 4th word arrives -> 4 pops on consecutive cycles.
REQ-042 The bench SHALL cover: out_ready = 0 for 5 cycles mid-burst -> out_data and out_valid stable, fifo_rd = 0; on release there is no lost or duplicated beat.
REQ-043 The bench SHALL cover: abort in BURST after 2 beats of req_len = 8 -> fifo_clr pulses once, out_valid drops, no done, req_ready = 1 next cycle.
REQ-044 The bench SHALL cover: req_len = 0 -> done pulses 1 cycle after acceptance, with no fifo_rd and no out_valid.
REQ-045 The bench SHALL cover: r_reset asserted in DRAIN with out_valid = 1 -> next cycle all outputs at their reset values and fifo_clr = 0.
